// File: rtl/axis_frame_rr_arbiter.sv
// ============================================================================
// Module      : axis_frame_rr_arbiter
// Description : Frame-granular round-robin AXI-stream arbiter/mux that holds
//               each grant from the first beat to tlast.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_frame_rr_arbiter #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [PORTS-1:0]              s_axis_tvalid,
  output logic [PORTS-1:0]              s_axis_tready,
  input  logic [PORTS-1:0]              s_axis_tlast,
  input  logic [PORTS-1:0]              s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  output logic                          grant_valid,
  output logic [$clog2(PORTS)-1:0]      grant_index
);

  localparam int IW = $clog2(PORTS);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  logic [0:0]            r_state;
  logic [IW-1:0]         r_grant_index;
  logic [IW-1:0]         r_last_grant;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic                  r_m_tvalid;
  logic                  r_m_tlast;
  logic                  r_m_tuser;

  logic [DATA_WIDTH-1:0] w_src_data [PORTS];
  logic [IW-1:0]         w_cand;
  logic [IW-1:0]         w_winner;
  logic                  w_found;
  logic                  w_out_ready;
  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic                  w_sel_user;
  logic                  w_accept;

  // Explicit wrap keeps non-power-of-2 PORTS inside the legal index range.
  function automatic logic [IW-1:0] f_next(input logic [IW-1:0] v);
    if (v == IW'(PORTS - 1)) begin
      return '0;
    end
    return v + IW'(1);
  endfunction

  generate
    for (genvar i = 0; i < PORTS; i++) begin : g_src
      assign w_src_data[i]    = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      assign s_axis_tready[i] = (r_state == S_ACTIVE) && w_out_ready &&
                                (r_grant_index == IW'(i));
    end
  endgenerate

  always_comb begin
    w_cand   = r_last_grant;
    w_winner = r_last_grant;
    w_found  = 1'b0;
    for (int k = 0; k < PORTS; k++) begin
      w_cand = f_next(w_cand);
      if (!w_found && s_axis_tvalid[w_cand]) begin
        w_winner = w_cand;
        w_found  = 1'b1;
      end
    end
  end

  // Skid-free output stage: a new beat may enter whenever the register drains.
  assign w_out_ready = m_axis_tready | ~r_m_tvalid;
  assign w_sel_valid = s_axis_tvalid[r_grant_index];
  assign w_sel_last  = s_axis_tlast[r_grant_index];
  assign w_sel_user  = s_axis_tuser[r_grant_index];
  assign w_accept    = (r_state == S_ACTIVE) && w_sel_valid && w_out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_grant_index <= '0;
      r_last_grant  <= IW'(PORTS - 1);
      r_m_tdata     <= '0;
      r_m_tvalid    <= 1'b0;
      r_m_tlast     <= 1'b0;
      r_m_tuser     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|s_axis_tvalid) begin
            r_grant_index <= w_winner;
            r_state       <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (w_accept && w_sel_last) begin
            r_last_grant <= r_grant_index;
            r_state      <= S_IDLE;
          end
        end
      endcase

      if (w_accept) begin
        r_m_tdata  <= w_src_data[r_grant_index];
        r_m_tlast  <= w_sel_last;
        r_m_tuser  <= w_sel_user;
        r_m_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        r_m_tvalid <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign m_axis_tuser  = r_m_tuser;
  assign grant_valid   = (r_state == S_ACTIVE);
  assign grant_index   = r_grant_index;

endmodule

`default_nettype wire
